// File: rtl/ebrick_arb_pkg.sv
// Shared types and mode constants for the ebrick UMI port arbiter.
package ebrick_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam logic [1:0] ARB_PRIO = 2'b00;
  localparam logic [1:0] ARB_RR   = 2'b10;

  // Every non-priority encoding collapses onto round-robin.
  function automatic logic [1:0] arb_mode_norm(input logic [1:0] mode);
    return (mode == ARB_PRIO) ? ARB_PRIO : ARB_RR;
  endfunction

endpackage

// File: rtl/ebrick_arb_rr_pick.sv
// Combinational picker: first set bit of elig at or above ptr, wrapping to the
// lowest set bit when nothing at or above ptr is set. ptr=0 gives fixed priority.
module ebrick_arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_elig;
  logic [N-1:0] cand;

  for (genvar gi = 0; gi < N; gi++) begin : g_hi_mask
    assign hi_mask[gi] = (PW'(gi) >= ptr);
  end

  assign hi_elig = elig & hi_mask;
  assign cand    = (|hi_elig) ? hi_elig : elig;
  // Isolate the lowest set bit of the candidate vector.
  assign grant   = cand & (~cand + N'(1));

endmodule

// File: rtl/ebrick_umi_arbiter.sv
// Packet-aware N-to-1 arbiter for one ebrick UMI host port; holds the grant until eom.
// Optional request aging is enabled by defining EBRICK_ARB_AGE_EN.
module ebrick_umi_arbiter
  import ebrick_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int AGE_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [1:0]           mode,
  input  logic [N-1:0]         mask,
  input  logic [N-1:0]         in_request,
  input  logic [N-1:0]         in_eom,
  input  logic                 out_ready,
  output logic [N-1:0]         in_ready,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] sel,
  output logic                 out_valid,
  output logic                 locked
);

  localparam int PW = $clog2(N);

`ifdef EBRICK_ARB_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  arb_state_e    state_reg, state_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic [PW-1:0] ptr_reg, ptr_next;

  logic [N-1:0]  elig;
  logic [N-1:0]  rr_grant;
  logic [N-1:0]  prio_grant;
  logic [N-1:0]  aged_grant;
  logic [N-1:0]  arb_grant;
  logic [N-1:0]  grant_int;
  logic [PW-1:0] sel_int;
  logic          any_aged;
  logic          use_rr;
  logic          accept;
  logic          eom_sel;

  assign elig   = in_request & ~mask;
  assign use_rr = (arb_mode_norm(mode) == ARB_RR);

  ebrick_arb_rr_pick #(.N(N)) u_rr_pick (
    .elig  (elig),
    .ptr   (ptr_reg),
    .grant (rr_grant)
  );

  ebrick_arb_rr_pick #(.N(N)) u_prio_pick (
    .elig  (elig),
    .ptr   ('0),
    .grant (prio_grant)
  );

  if (AGE_EN && AGE_LIMIT > 0) begin : g_age
    localparam int AW = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    logic [N-1:0] aged;

    for (genvar gi = 0; gi < N; gi++) begin : g_cnt
      logic [AW-1:0] wait_reg;

      // A granted-but-stalled requester holds its count rather than clearing it.
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          wait_reg <= '0;
        end else if (!elig[gi] || (accept && grant_int[gi])) begin
          wait_reg <= '0;
        end else if (!grant_int[gi] && (wait_reg != AGE_MAX)) begin
          wait_reg <= wait_reg + AW'(1);
        end
      end

      assign aged[gi] = elig[gi] && (wait_reg == AGE_MAX);
    end

    ebrick_arb_rr_pick #(.N(N)) u_aged_pick (
      .elig  (aged),
      .ptr   ('0),
      .grant (aged_grant)
    );

    assign any_aged = |aged;
  end else begin : g_no_age
    assign aged_grant = '0;
    assign any_aged   = 1'b0;
  end

  always_comb begin
    arb_grant = use_rr ? rr_grant : prio_grant;
    if (any_aged) begin
      arb_grant = aged_grant;
    end
  end

  // Outputs are forced quiet while reset is held, even with requests present.
  always_comb begin
    grant_int = '0;
    if (nreset) begin
      grant_int = (state_reg == LOCK) ? grant_reg : arb_grant;
    end
  end

  always_comb begin
    sel_int = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_int[i]) begin
        sel_int = sel_int | PW'(i);
      end
    end
  end

  assign eom_sel = in_eom[sel_int];
  assign accept  = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    if (accept) begin
      if (eom_sel) begin
        state_next = IDLE;
        ptr_next   = (sel_int == PW'(N - 1)) ? '0 : sel_int + PW'(1);
      end else if (state_reg == IDLE) begin
        state_next = LOCK;
        grant_next = grant_int;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign grant     = grant_int;
  assign sel       = sel_int;
  assign in_ready  = grant_int & {N{out_ready}};
  assign out_valid = |(grant_int & in_request);
  assign locked    = (state_reg == LOCK);

endmodule

// File: tb/tb_ebrick_umi_arbiter.sv
// Self-checking bench for ebrick_umi_arbiter: vector table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_ebrick_umi_arbiter;

  localparam int N         = 4;
  localparam int AGE_LIMIT = 15;
`ifdef EBRICK_ARB_AGE_EN
  localparam bit AGED = 1'b1;
`else
  localparam bit AGED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nreset;
  logic [1:0] mode;
  logic [3:0] mask;
  logic [3:0] in_request;
  logic [3:0] in_eom;
  logic       out_ready;
  logic [3:0] in_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out_valid;
  logic       locked;

  always #5 clk = ~clk;

  ebrick_umi_arbiter #(.N(N), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .mode       (mode),
    .mask       (mask),
    .in_request (in_request),
    .in_eom     (in_eom),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .grant      (grant),
    .sel        (sel),
    .out_valid  (out_valid),
    .locked     (locked)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] mask;
    logic [3:0] req;
    logic [3:0] eom;
    logic       rdy;
    logic [3:0] exp_grant;
    logic       exp_ov;
    logic       exp_lk;
  } vec_t;

  vec_t vecs[10];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Random-test model state
  int         m_ptr;
  bit         m_lock;
  int         m_held;
  int         m_age[N];
  int         win;
  logic [1:0] r_mode;
  logic [3:0] r_mask, r_req, r_eom, r_elig, r_grant;
  logic       r_rdy, r_ov, r_acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("  ok   %-10s out=%03h", name, got[11:0]);
    end else begin
      $display("FAIL %s: got %03h expected %03h", name, got[11:0], exp[11:0]);
    end
  endtask

  // {locked, out_valid, sel, in_ready, grant}
  function automatic logic [31:0] pack_out();
    return {20'd0, locked, out_valid, sel, in_ready, grant};
  endfunction

  function automatic logic [31:0] pack_exp(input logic [3:0] g, input logic ov,
                                           input logic rdy, input logic lk);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) s = 2'(i);
    end
    return {20'd0, lk, ov, s, g & {4{rdy}}, g};
  endfunction

  task automatic drive(input logic [1:0] m, input logic [3:0] mk, input logic [3:0] rq,
                       input logic [3:0] eo, input logic rd);
    mode       = m;
    mask       = mk;
    in_request = rq;
    in_eom     = eo;
    out_ready  = rd;
  endtask

  task automatic step(input string name, input logic [1:0] m, input logic [3:0] mk,
                      input logic [3:0] rq, input logic [3:0] eo, input logic rd,
                      input logic [3:0] eg, input logic ov, input logic lk);
    @(negedge clk);
    drive(m, mk, rq, eo, rd);
    #1;
    check(name, pack_out(), pack_exp(eg, ov, rd, lk));
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    drive(2'b10, 4'b0000, 4'b1111, 4'b1111, 1'b1);
    #1;
    check("reset", pack_out(), 32'd0);
    @(negedge clk);
    drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    nreset = 1'b1;
  endtask

  initial begin
    nreset = 1'b0;
    drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    //          mode   mask     req      eom      rdy   grant    ov    lk
    vecs[0] = '{2'b00, 4'b0000, 4'b0110, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 4'b0000, 4'b0110, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0};
    vecs[2] = '{2'b10, 4'b0000, 4'b0111, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0};
    vecs[3] = '{2'b00, 4'b0000, 4'b0111, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[4] = '{2'b10, 4'b0001, 4'b0001, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 4'b0000, 4'b0011, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 4'b0000, 4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0};
    vecs[7] = '{2'b11, 4'b0000, 4'b1001, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[8] = '{2'b01, 4'b0000, 4'b1010, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[9] = '{2'b10, 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), vecs[i].mode, vecs[i].mask, vecs[i].req, vecs[i].eom,
           vecs[i].rdy, vecs[i].exp_grant, vecs[i].exp_ov, vecs[i].exp_lk);
    end

    // Round-robin rotation with single-beat messages, back to back
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step($sformatf("rr%0d", i), 2'b10, 4'b0000, 4'b1111, 4'b1111, 1'b1,
           4'(1 << (i % 4)), 1'b1, 1'b0);
    end

    // Requester 2 three-beat message with a stall and a mid-packet request drop
    do_reset();
    step("lock_b1",   2'b00, 4'b0000, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0);
    step("lock_stl",  2'b00, 4'b0000, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1);
    step("lock_drop", 2'b00, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b1);
    step("lock_b2",   2'b00, 4'b0000, 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1);
    step("lock_b3",   2'b00, 4'b0000, 4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1);
    step("lock_next", 2'b00, 4'b0000, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0);

    // Mask raised during a requester-0 lock does not drop the grant
    do_reset();
    step("mask_b1",   2'b00, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0);
    step("mask_b2",   2'b00, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1);
    step("mask_b3",   2'b00, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1);
    step("mask_idle", 2'b00, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a locked packet
    do_reset();
    step("rst_b1", 2'b10, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0);
    step("rst_b2", 2'b10, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1);
    #1 nreset = 1'b0;
    #1 check("rst_async", pack_out(), 32'd0);
    @(negedge clk);
    drive(2'b10, 4'b0000, 4'b1000, 4'b1111, 1'b0);
    nreset = 1'b1;
    #1 check("rst_after", pack_out(), pack_exp(4'b1000, 1'b1, 1'b0, 1'b0));
    step("rst_hold", 2'b10, 4'b0000, 4'b1000, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0);

    // Fixed priority contention: requester 3 is promoted only when aging is built in
    do_reset();
    for (int c = 0; c < AGE_LIMIT + 2; c++) begin
      step($sformatf("age%0d", c), 2'b00, 4'b0000, 4'b1001, 4'b1111, 1'b1,
           (AGED && c == AGE_LIMIT) ? 4'b1000 : 4'b0001, 1'b1, 1'b0);
    end

    // Randomized traffic against the reference model
    do_reset();
    m_ptr  = 0;
    m_lock = 1'b0;
    m_held = 0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      r_mode = 2'($urandom_range(0, 3));
      r_mask = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      r_req  = 4'($urandom) | 4'($urandom);
      r_eom  = 4'($urandom);
      r_rdy  = ($urandom_range(0, 3) != 0);
      drive(r_mode, r_mask, r_req, r_eom, r_rdy);
      #1;
      r_elig = r_req & ~r_mask;
      win = -1;
      if (m_lock) begin
        win = m_held;
      end else begin
        if (AGED) begin
          for (int i = 0; i < N; i++)
            if (win < 0 && r_elig[i] && m_age[i] == AGE_LIMIT) win = i;
        end
        if (win < 0) begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (r_mode == 2'b00) ? k : (m_ptr + k) % N;
            if (win < 0 && r_elig[idx]) win = idx;
          end
        end
      end
      r_grant = (win < 0) ? 4'b0000 : 4'(1 << win);
      r_ov    = (win >= 0) && r_req[win];
      r_acc   = r_ov && r_rdy;
      check("rand", pack_out(), pack_exp(r_grant, r_ov, r_rdy, m_lock));
      for (int i = 0; i < N; i++) begin
        if (!r_elig[i] || (r_acc && win == i)) m_age[i] = 0;
        else if (!r_grant[i] && m_age[i] < AGE_LIMIT) m_age[i] = m_age[i] + 1;
      end
      if (r_acc) begin
        if (r_eom[win]) begin
          m_lock = 1'b0;
          m_ptr  = (win + 1) % N;
        end else if (!m_lock) begin
          m_lock = 1'b1;
          m_held = win;
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
